sseg_scan_driver: RTL and testbench

- Downstream display stage for the adder datapath. Takes four BCD digits (ones through thousands) from the binary-to-BCD converter.
- Time-multiplexes them onto a 4-digit common-anode seven-segment display (Basys3 style, active-low anodes and cathodes).
- Snapshots the input digits once per scan frame so the display never tears.
- Inserts a per-digit anode blanking window to suppress ghosting.

---
 rtl/sseg_scan_driver.sv | 112 +++++++++++
 tb/tb_sseg_scan_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module sseg_scan_driver #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned BLANK    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] one,
    input  logic [3:0] ten,
    input  logic [3:0] hunnid,
    input  logic [3:0] thousand,
    output logic [3:0] seg_an,
    output logic [6:0] seg_cat,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic [15:0]      snap;
    logic             load_pending;

    logic       slot_end_c;
    logic       capture_c;
    logic       blank_c;
    logic       lz_blank_c;
    logic [3:0] cur_digit_c;

    // Active-high gfedcba pattern; non-BCD codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    always_comb begin
        slot_end_c = (cnt == CNT_W'(PRESCALE - 1));
        capture_c  = load_pending || (slot_end_c && (dig == 2'd3));
        blank_c    = (32'(cnt) < BLANK);
        case (dig)
            2'd0:    cur_digit_c = snap[3:0];
            2'd1:    cur_digit_c = snap[7:4];
            2'd2:    cur_digit_c = snap[11:8];
            default: cur_digit_c = snap[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        case (dig)
            2'd3:    lz_blank_c = (snap[15:12] == 4'd0);
            2'd2:    lz_blank_c = (snap[15:8] == 8'd0);
            2'd1:    lz_blank_c = (snap[15:4] == 12'd0);
            default: lz_blank_c = 1'b0;
        endcase
    end
`else
    always_comb begin
        lz_blank_c = 1'b0;
    end
`endif

    // Slot/digit scan, frame snapshot and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            dig          <= 2'd0;
            snap         <= 16'h0000;
            load_pending <= 1'b1;
            seg_an       <= 4'b1111;
            seg_cat      <= 7'b1111111;
            frame_tick   <= 1'b0;
        end else begin
            if (slot_end_c) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture_c) begin
                snap <= {thousand, hunnid, ten, one};
            end
            load_pending <= 1'b0;
            frame_tick   <= capture_c;

            if (blank_c) begin
                seg_an  <= 4'b1111;
                seg_cat <= 7'b1111111;
            end else begin
                seg_an  <= ~(4'b0001 << dig);
                seg_cat <= lz_blank_c ? 7'b1111111 : ~decode(cur_digit_c);
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: a cycle-count reference model predicts each output cycle.
module tb_sseg_scan_driver;

    localparam int unsigned P = 8;
    localparam int unsigned B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] one, ten, hunnid, thousand;
    logic [3:0] seg_an;
    logic [6:0] seg_cat;
    logic       frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       ft;
    } exp_t;

    exp_t        q[$];
    int unsigned n_edges;
    int unsigned m_snap[4];
    int          checks = 0;
    int          passes = 0;

    sseg_scan_driver #(.PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .one        (one),
        .ten        (ten),
        .hunnid     (hunnid),
        .thousand   (thousand),
        .seg_an     (seg_an),
        .seg_cat    (seg_cat),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pattern(input int unsigned v);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 9) return 7'h40;
        return tbl[v];
    endfunction

    // Reference: position in the scan follows from the number of edges since reset release
    always @(posedge clk) begin : model
        exp_t        e;
        int unsigned c, d;
        bit          blank;
        if (!rst_n) begin
            n_edges = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            e.an = 4'hF; e.cat = 7'h7F; e.ft = 1'b0;
        end else begin
            n_edges++;
            c = (n_edges - 1) % P;
            d = ((n_edges - 1) / P) % 4;
            if (c < B) begin
                e.an = 4'hF; e.cat = 7'h7F;
            end else begin
                e.an  = ~(4'b0001 << d);
                blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (d > 0) begin
                    blank = 1'b1;
                    for (int k = 0; k < 4; k++)
                        if (k >= int'(d) && m_snap[k] != 0) blank = 1'b0;
                end
`endif
                e.cat = blank ? 7'h7F : ~pattern(m_snap[d]);
            end
            e.ft = (n_edges == 1) || (n_edges % (4 * P) == 0);
            if (e.ft) begin
                m_snap[0] = one; m_snap[1] = ten; m_snap[2] = hunnid; m_snap[3] = thousand;
            end
        end
        q.push_back(e);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg_an", int'(seg_an), int'(e.an));
            chk("seg_cat", int'(seg_cat), int'(e.cat));
            chk("frame_tick", int'(frame_tick), int'(e.ft));
            chk("one_anode", ($countones(~seg_an) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te, input logic [3:0] o);
        thousand = t; hunnid = h; ten = te; one = o;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        step(3);
        rst_n = 1'b1;
        step(4 * P + P + 3);
        set_in(4'd9, 4'd9, 4'd9, 4'd9);
        step(8 * P);
        one = 4'hC;
        step(8 * P);
        set_in(4'd0, 4'd0, 4'd0, 4'd7);
        step(8 * P);
        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        step(8 * P);
        set_in(4'd0, 4'd5, 4'd0, 4'd0);
        step(8 * P);
        // Reset lands while slot 2 is at cnt=5
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(21);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(8 * P);
        for (int k = 0; k < 30; k++) begin
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) thousand = 4'd0;
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            step($urandom_range(1, 50));
        end
        step(2);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
